fp16_mul_stream_ctrl: RTL

Stream controller for the FP16 multiplier. It accepts operand pairs over a valid/ready stream, registers them onto the multiplier's operand inputs, and tags each issue with a valid/last shift register matched to the multiplier's pipeline depth. It captures the results into a small FIFO and presents them on a valid/ready output stream. Credit-based issue keeps the FIFO from overflowing even though the multiplier itself has no backpressure.

---
 rtl/fp16_mul_stream_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fp16_mul_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fp16_mul_stream_ctrl
//
// Stream wrapper around an external, non-stallable FP16 multiplier pipeline.
// Operand pairs are accepted on a valid/ready stream and registered onto the
// multiplier operand inputs. A valid/last tag travels alongside each issue
// through a shift register that matches the multiplier depth. Results are
// captured into a small show-ahead FIFO and presented on a valid/ready
// output stream.
//
// Credit scheme: every item holds one credit from its accept edge until its
// pop edge. Because a new pair is only accepted while the number of tagged
// in-flight items plus buffered results is below FIFO_DEPTH, the FIFO can
// never be written while full, even though the multiplier cannot be stalled.
//
// Optional build macro: FP16_MUL_OP_GATE_EN
//   defined   -> mul_a/mul_b read as zero on every cycle that does not
//                directly follow an accept (suppresses multiplier toggling)
//   undefined -> mul_a/mul_b hold the most recently accepted operands
//   The out_* stream behaves identically in both builds.
//
// Parameters:
//   MUL_LATENCY  multiplier pipeline registers (>= 1)
//   FIFO_DEPTH   result FIFO entries (>= 2, need not be a power of two)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous drop of in-flight and buffered results
//   in_valid/in_ready     operand stream handshake
//   in_a, in_b, in_last   operand pair and end-of-vector marker
//   mul_a, mul_b          registered operands to the multiplier
//   mul_res               multiplier result (MUL_LATENCY edges after operands)
//   out_valid/out_ready   result stream handshake
//   out_data, out_last    FIFO head product and its last flag
//   busy                  at least one item in flight or buffered
// ---------------------------------------------------------------------------
module fp16_mul_stream_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy
);

  // Counter widths: outstanding and fifo_count both range 0..FIFO_DEPTH.
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [OW-1:0] DEPTH_C  = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [OW-1:0]        fifo_count_q, fifo_count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

  // Tag stage i lines up with the operands that entered the multiplier
  // i edges ago; stage MUL_LATENCY lines up with mul_res.
  logic [MUL_LATENCY:0] tag_valid_q, tag_valid_d;
  logic [MUL_LATENCY:0] tag_last_q, tag_last_d;

  logic [15:0]          fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;

  logic [15:0]          op_a_q, op_b_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic accept;
  logic fifo_push;
  logic fifo_pop;

  // Credit check uses registered state only: a pop in this cycle frees its
  // credit for the next cycle, not this one.
  assign in_ready  = !flush && (outstanding_q < DEPTH_C);
  assign accept    = in_valid && in_ready;

  assign fifo_push = tag_valid_q[MUL_LATENCY];
  assign out_valid = (fifo_count_q != '0);
  assign fifo_pop  = out_valid && out_ready;

  // Show-ahead read: the head entry is always on the outputs.
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

  assign busy      = (outstanding_q != '0);

  // -------------------------------------------------------------------------
  // Next-state logic for tags, FIFO bookkeeping and credits
  // -------------------------------------------------------------------------
  always_comb begin
    tag_valid_d   = {tag_valid_q[MUL_LATENCY-1:0], accept};
    tag_last_d    = {tag_last_q[MUL_LATENCY-1:0], accept && in_last};
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    outstanding_d = outstanding_q;

    // Pointers wrap explicitly so a non-power-of-two depth works.
    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase

    unique case ({accept, fifo_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    // Flush forgets every in-flight tag, so results still inside the
    // multiplier arrive untagged and are never captured.
    if (flush) begin
      tag_valid_d   = '0;
      tag_last_d    = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fifo_count_d  = '0;
      outstanding_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q   <= '0;
      tag_last_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      outstanding_q <= '0;
    end else begin
      tag_valid_q   <= tag_valid_d;
      tag_last_q    <= tag_last_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // -------------------------------------------------------------------------
  // Result storage. Entries are reset so the head reads zero out of reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
    end else if (fifo_push && !flush) begin
      fifo_data_q[wr_ptr_q] <= mul_res;
      fifo_last_q[wr_ptr_q] <= tag_last_q[MUL_LATENCY];
    end
  end

  // -------------------------------------------------------------------------
  // Operand registers. Loaded only on accept; flush leaves them untouched.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      op_a_q <= in_a;
      op_b_q <= in_b;
    end
  end

`ifdef FP16_MUL_OP_GATE_EN
  // idle_q is set whenever the previous edge carried no accept, forcing the
  // multiplier inputs to zero so its datapath stops toggling between issues.
  logic op_idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_idle_q <= 1'b1;
    end else begin
      op_idle_q <= !accept;
    end
  end

  assign mul_a = op_idle_q ? 16'h0000 : op_a_q;
  assign mul_b = op_idle_q ? 16'h0000 : op_b_q;
`else
  assign mul_a = op_a_q;
  assign mul_b = op_b_q;
`endif

endmodule
